// File: rtl/line_pkg.sv
// Shared types and constants for the line scheduler: framebuffer geometry,
// field widths, FSM state names, the line command record and address math.
package line_pkg;

  localparam int FB_WIDTH_DEFAULT  = 640;
  localparam int FB_HEIGHT_DEFAULT = 400;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 4;
  localparam int ADDR_W  = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [X_W-1:0]     x1;
    logic [Y_W-1:0]     y1;
    logic [COLOR_W-1:0] color;
  } line_cmd_t;

  // y*width + x as a sum of shifted copies of y, one per set bit of the
  // constant width; with width elaborated as a constant this folds to adders.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y,
                                                  input int width);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(x);
    for (int i = 0; i < ADDR_W; i++) begin
      if (width[i]) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/line_scheduler_if.sv
// Bundle of the requester, rasteriser and framebuffer handshakes seen by the
// line scheduler. master = scheduler side, slave = surrounding logic.
interface line_scheduler_if;
  import line_pkg::*;

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0][X_W-1:0]     req_x0;
  logic [1:0][X_W-1:0]     req_x1;
  logic [1:0][Y_W-1:0]     req_y0;
  logic [1:0][Y_W-1:0]     req_y1;
  logic [1:0][COLOR_W-1:0] req_color;

  logic                    ras_start;
  logic [X_W-1:0]          ras_x0;
  logic [X_W-1:0]          ras_x1;
  logic [Y_W-1:0]          ras_y0;
  logic [Y_W-1:0]          ras_y1;
  logic                    ras_pixel_valid;
  logic [X_W-1:0]          ras_x;
  logic [Y_W-1:0]          ras_y;
  logic                    ras_stall;
  logic                    ras_done;

  logic                    pix_valid;
  logic                    pix_ready;
  logic [ADDR_W-1:0]       pix_addr;
  logic [COLOR_W-1:0]      pix_color;

  modport master (
    input  req_valid, req_x0, req_x1, req_y0, req_y1, req_color,
    output req_ready,
    output ras_start, ras_x0, ras_x1, ras_y0, ras_y1, ras_stall,
    input  ras_pixel_valid, ras_x, ras_y, ras_done,
    output pix_valid, pix_addr, pix_color,
    input  pix_ready
  );

  modport slave (
    output req_valid, req_x0, req_x1, req_y0, req_y1, req_color,
    input  req_ready,
    input  ras_start, ras_x0, ras_x1, ras_y0, ras_y1, ras_stall,
    output ras_pixel_valid, ras_x, ras_y, ras_done,
    input  pix_valid, pix_addr, pix_color,
    output pix_ready
  );

endinterface

// File: rtl/line_rr_arbiter.sv
// Two-way round-robin arbiter: the pointer requester wins a tie, a lone
// requester always wins, and after each grant the pointer moves past the winner.
module line_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // Grant the pointer requester first, otherwise the other one.
  // NOTE: grant gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    grant = 2'b00;
    if (valid[ptr])       grant[ptr]  = 1'b1;
    else if (valid[~ptr]) grant[~ptr] = 1'b1;
  end

  // Move the pointer to the requester that did not win.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     ptr <= 1'b0;
    else if (advance && |grant)    ptr <= ~grant[1];
  end

endmodule

// File: rtl/line_scheduler.sv
// Line scheduler: arbitrates two command sources, launches the rasteriser,
// clips its pixel stream to the framebuffer and forwards visible pixels through
// a one-entry buffer with backpressure, counting completed lines.
module line_scheduler
  import line_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEFAULT,
  parameter int FB_HEIGHT = FB_HEIGHT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  line_scheduler_if.master bus,
  output logic             busy,
  output logic [15:0]      lines_done
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] LAUNCH = ST_LAUNCH;
  localparam logic [1:0] DRAW   = ST_DRAW;
  localparam logic [1:0] FLUSH  = ST_FLUSH;

  logic [1:0]         state;
  logic [1:0]         grant;
  logic               take;
  logic               sel;
  logic               on_screen;
  logic               pix_take;
  line_cmd_t          cmd;
  line_cmd_t          req_cmd;
  logic               pv;
  logic [ADDR_W-1:0]  addr_q;
  logic [COLOR_W-1:0] color_q;

  assign take = (state == IDLE) && (|bus.req_valid);

  line_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (bus.req_valid),
    .advance (take),
    .grant   (grant)
  );

  assign sel     = grant[1];
  assign req_cmd = '{x0: bus.req_x0[sel], y0: bus.req_y0[sel],
                     x1: bus.req_x1[sel], y1: bus.req_y1[sel],
                     color: bus.req_color[sel]};

  assign bus.req_ready = (state == IDLE) ? grant : 2'b00;
  assign bus.ras_start = (state == LAUNCH);
  assign bus.ras_x0    = cmd.x0;
  assign bus.ras_x1    = cmd.x1;
  assign bus.ras_y0    = cmd.y0;
  assign bus.ras_y1    = cmd.y1;
  assign bus.ras_stall = pv & ~bus.pix_ready;
  assign bus.pix_valid = pv;
  assign bus.pix_addr  = addr_q;
  assign bus.pix_color = color_q;
  assign busy          = (state != IDLE);

  // Off-screen pixels are consumed without entering the buffer.
  assign on_screen = (int'(bus.ras_x) < FB_WIDTH) && (int'(bus.ras_y) < FB_HEIGHT);
  assign pix_take  = (state == DRAW) && bus.ras_pixel_valid && !bus.ras_stall && on_screen;

  // One-entry output buffer: load a visible pixel, empty it on a framebuffer accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv      <= 1'b0;
      addr_q  <= '0;
      color_q <= '0;
    end else if (pix_take) begin
      pv      <= 1'b1;
      addr_q  <= line_addr(bus.ras_x, bus.ras_y, FB_WIDTH);
      color_q <= cmd.color;
    end else if (pv && bus.pix_ready) begin
      pv      <= 1'b0;
    end
  end

  // Command sequencing: grant, launch, draw until done, drain, count the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd        <= '0;
      lines_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            cmd   <= req_cmd;
            state <= LAUNCH;
          end
        end
        LAUNCH: state <= DRAW;
        DRAW: begin
          if (bus.ras_done) state <= FLUSH;
        end
        default: begin
          if (!pv) begin
            lines_done <= lines_done + 16'd1;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
